// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: resolves cache waits, load-use hazards and branch flushes into pipeline stall/bubble/flush controls.
module pipeline_stall_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [REG_W-1:0] id_sr1,
  input  logic [REG_W-1:0] id_sr2,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             br_taken,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             flush_ex_mem,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] dstall_cnt,
  output logic [CNT_W-1:0] istall_cnt,
  output logic [CNT_W-1:0] lu_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, DSTALL = 2'd1, ISTALL = 2'd2} state_t;
  state_t state, state_nxt;
  logic pending_flush, pending_nxt;
  logic dwait, iwait, lu, flush, lu_bub;
  assign dwait  = dmem_req & ~dmem_resp;
  assign iwait  = imem_req & ~imem_resp;
  assign lu     = ex_valid & ex_is_load &
                  ((id_uses_sr1 & (id_sr1 == ex_dest)) | (id_uses_sr2 & (id_sr2 == ex_dest)));
  assign flush  = ~dwait & (br_taken | pending_flush);
  assign lu_bub = ~dwait & ~flush & ~iwait & lu;
  always_comb begin
    state_nxt    = dwait ? DSTALL : (iwait ? ISTALL : RUN);
    pending_nxt  = dwait & (pending_flush | br_taken);
    // Outputs are gated by rst_n so they drop the instant reset asserts.
    stall_if_id  = rst_n & (dwait | (~flush & (iwait | lu)));
    stall_id_ex  = rst_n & dwait;
    stall_ex_mem = rst_n & dwait;
    stall_mem_wb = rst_n & dwait;
    bubble_id_ex = rst_n & (flush | (~dwait & (iwait | lu)));
    flush_if_id  = rst_n & flush;
    flush_ex_mem = rst_n & flush;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      dstall_cnt    <= '0;
      istall_cnt    <= '0;
      lu_cnt        <= '0;
    end else begin
      state         <= state_nxt;
      pending_flush <= pending_nxt;
      dstall_cnt    <= dstall_cnt + CNT_W'((state == DSTALL) && ~&dstall_cnt);
      istall_cnt    <= istall_cnt + CNT_W'((state == ISTALL) && ~&istall_cnt);
      lu_cnt        <= lu_cnt + CNT_W'(lu_bub && ~&lu_cnt);
    end
  end
  assign state_o = state;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: scoreboard bench comparing the stall controller against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, rst_n = 0;
  logic imem_req = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
  logic [2:0] id_sr1 = 0, id_sr2 = 0, ex_dest = 0;
  logic id_uses_sr1 = 0, id_uses_sr2 = 0, ex_valid = 0, ex_is_load = 0, br_taken = 0;
  logic stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_id_ex, flush_if_id, flush_ex_mem;
  logic [1:0] state_o;
  logic [CW-1:0] dstall_cnt, istall_cnt, lu_cnt;
  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] st;
    logic [CW-1:0] d, i, l;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, pushes = 0, pops = 0;
  int m_st = 0, m_d = 0, m_i = 0, m_l = 0;
  bit m_pf = 0;
  wire [6:0] ctl = {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_id_ex, flush_if_id, flush_ex_mem};

  pipeline_stall_ctrl #(.REG_W(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest), .br_taken(br_taken),
    .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
    .stall_mem_wb(stall_mem_wb), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .flush_ex_mem(flush_ex_mem), .state_o(state_o), .dstall_cnt(dstall_cnt),
    .istall_cnt(istall_cnt), .lu_cnt(lu_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, want, $time);
    end
  endtask

  function automatic int sat(input int v);
    return v > MAXC ? MAXC : v;
  endfunction

  // One pipeline cycle: drive inputs, predict this cycle's outputs, advance the model.
  task automatic step(input bit ir, irs, dr, drs, br, exv, exl, u1, u2, input int s1, s2, dst);
    bit dw, iw, lu, lu_now;
    exp_t e;
    @(posedge clk); #1;
    imem_req = ir; imem_resp = irs; dmem_req = dr; dmem_resp = drs; br_taken = br;
    ex_valid = exv; ex_is_load = exl; id_uses_sr1 = u1; id_uses_sr2 = u2;
    id_sr1 = 3'(s1); id_sr2 = 3'(s2); ex_dest = 3'(dst);
    dw = dr && !drs;
    iw = ir && !irs;
    lu = exv && exl && ((u1 && s1 == dst) || (u2 && s2 == dst));
    lu_now = 0;
    e.ctl = 7'b0;
    if (dw) e.ctl = 7'b1111000;
    else if (br || m_pf) e.ctl = 7'b0000111;
    else if (iw) e.ctl = 7'b1000100;
    else if (lu) begin e.ctl = 7'b1000100; lu_now = 1; end
    e.st = 2'(m_st); e.d = CW'(m_d); e.i = CW'(m_i); e.l = CW'(m_l);
    q.push_back(e);
    pushes++;
    m_d = sat(m_d + (m_st == 1 ? 1 : 0));
    m_i = sat(m_i + (m_st == 2 ? 1 : 0));
    m_l = sat(m_l + (lu_now ? 1 : 0));
    m_st = dw ? 1 : (iw ? 2 : 0);
    m_pf = dw ? (m_pf | br) : 1'b0;
  endtask

  task automatic idle();
    step(0,0,0,0,0,0,0,0,0,0,0,0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ctl"}, 32'(ctl), 0);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_dcnt"}, 32'(dstall_cnt), 0);
    chk({tag, "_icnt"}, 32'(istall_cnt), 0);
    chk({tag, "_lcnt"}, 32'(lu_cnt), 0);
  endtask

  // Asynchronous reset in the middle of a cycle with a D-miss still outstanding.
  task automatic async_reset(input string tag);
    @(posedge clk); #1;
    dmem_req = 1; dmem_resp = 0; br_taken = 0;
    #2 rst_n = 0;
    #1 check_reset_state(tag);
    {imem_req, imem_resp, dmem_req, dmem_resp, br_taken, ex_valid, ex_is_load, id_uses_sr1, id_uses_sr2} = '0;
    @(posedge clk); #1 rst_n = 1;
    m_st = 0; m_d = 0; m_i = 0; m_l = 0; m_pf = 0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      pops++;
      chk("ctl", 32'(ctl), 32'(e.ctl));
      chk("state", 32'(state_o), 32'(e.st));
      chk("dstall_cnt", 32'(dstall_cnt), 32'(e.d));
      chk("istall_cnt", 32'(istall_cnt), 32'(e.i));
      chk("lu_cnt", 32'(lu_cnt), 32'(e.l));
    end
  end

  initial begin
    #3 check_reset_state("init_reset");
    @(posedge clk); #1 rst_n = 1;
    repeat (3) step(0,0,1,0,0,0,0,0,0,0,0,0);
    step(0,0,1,1,0,0,0,0,0,0,0,0);
    repeat (2) idle();
    step(0,0,1,0,0,0,0,0,0,0,0,0);
    step(0,0,1,0,1,0,0,0,0,0,0,0);
    step(0,0,1,0,0,0,0,0,0,0,0,0);
    step(0,0,1,1,0,0,0,0,0,0,0,0);
    repeat (2) idle();
    step(0,0,0,0,0,1,1,0,1,5,3,3);
    step(0,0,0,0,0,1,1,0,0,5,3,3);
    step(1,0,0,0,0,1,1,1,0,3,1,3);
    step(1,0,0,0,0,1,1,1,0,3,1,3);
    repeat (2) idle();
    repeat (20) step(0,0,1,0,0,0,0,0,0,0,0,0);
    step(0,0,1,1,0,0,0,0,0,0,0,0);
    repeat (2) idle();
    step(0,0,1,0,1,0,0,0,0,0,0,0);
    step(0,0,1,0,0,0,0,0,0,0,0,0);
    async_reset("mid_dstall_reset");
    repeat (2) idle();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset("random_reset");
      step($urandom_range(0,1), $urandom_range(0,2) == 0, $urandom_range(0,1), $urandom_range(0,2) == 0,
           $urandom_range(0,7) == 0, $urandom_range(0,3) != 0, $urandom_range(0,1),
           $urandom_range(0,1), $urandom_range(0,1),
           int'($urandom_range(0,3)), int'($urandom_range(0,3)), int'($urandom_range(0,3)));
    end
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(pops), 32'(pushes));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central hazard/stall controller for the 5-stage LC-3b pipeline. It is the driver side of the per-register stall_pipeline inputs and the bubble/flush controls on IF_ID, ID_EX, EX_MEM and MEM_WB. It resolves I-cache waits, D-cache waits, load-use hazards and taken-branch flushes into one consistent set of stall/bubble/flush controls each cycle. It also keeps saturating stall-cycle performance counters.

Parameters:
REG_W, 3, register specifier width (lc3b_reg)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  in  1  IF stage has an I-cache request outstanding
imem_resp  in  1  I-cache response valid this cycle
dmem_req  in  1  MEM stage has a D-cache request outstanding
dmem_resp  in  1  D-cache response valid this cycle
id_sr1  in  REG_W  SR1 specifier of the instruction in ID
id_sr2  in  REG_W  SR2 specifier of the instruction in ID
id_uses_sr1  in  1  ID instruction reads SR1
id_uses_sr2  in  1  ID instruction reads SR2
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_is_load  in  1  EX instruction is LDR/LDB/LDI
ex_dest  in  REG_W  destination of EX instruction
br_taken  in  1  MEM stage resolved a taken branch/JMP/JSR/TRAP
stall_if_id  out  1  hold IF_ID and PC
stall_id_ex  out  1  hold ID_EX (drives its stall_pipeline)
stall_ex_mem  out  1  hold EX_MEM
stall_mem_wb  out  1  hold MEM_WB
bubble_id_ex  out  1  load NOP control word into ID_EX
flush_if_id  out  1  load NOP into IF_ID
flush_ex_mem  out  1  load NOP into EX_MEM
state_o  out  2  current FSM state (debug)
dstall_cnt  out  CNT_W  cycles spent in D-stall, saturating
istall_cnt  out  CNT_W  cycles spent in I-stall, saturating
lu_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n low, any time, asynchronous): state=RUN, pending_flush=0, all counters 0. All stall/bubble/flush outputs are 0 while in reset.
- Derived signals: dwait = dmem_req & ~dmem_resp; iwait = imem_req & ~imem_resp; lu = ex_valid & ex_is_load & ((id_uses_sr1 & id_sr1==ex_dest) | (id_uses_sr2 & id_sr2==ex_dest)).
- FSM states: RUN=0, DSTALL=1, ISTALL=2. Next state is decided each cycle from dwait/iwait, with dwait taking priority: dwait -> DSTALL; else iwait -> ISTALL; else RUN. Self-loops hold while the condition persists. DSTALL preempts ISTALL the same cycle.
- Outputs are combinational from the current cycle's conditions, priority high to low:
  1. dwait: all four stall_* =1. No bubble, no flush. If br_taken is also 1, set pending_flush on the clock edge.
  2. br_taken | pending_flush (no dwait): flush_if_id=1, bubble_id_ex=1, flush_ex_mem=1, stall_if_id=0. pending_flush clears on this edge. Only a flush is issued; no stall.
  3. iwait: stall_if_id=1, bubble_id_ex=1. Downstream stages run.
  4. lu: stall_if_id=1, bubble_id_ex=1 for exactly one cycle. The next cycle the load is in MEM with ex_valid=0, so lu deasserts naturally. No internal one-shot.
  5. Otherwise all 0.
- iwait and lu in the same cycle: one bubble covers both. lu_cnt does not increment when iwait is also true.
- Counters increment by 1 per cycle of their condition and saturate at all-ones (no wrap):
  - dstall_cnt: state==DSTALL
  - istall_cnt: state==ISTALL
  - lu_cnt: priority-4 bubble issued
- Response arrives in the same cycle as req (req&resp): no stall for that cycle.
- Reset mid-stall: all outputs drop to 0 immediately and pending_flush is lost. Upstream restarts from the reset PC.

Test Plan:
- Reset: assert rst_n=0 mid-DSTALL with dmem_req=1 -> all outputs 0 asynchronously, counters 0, state_o=0.
- D-miss: dmem_req=1 for 4 cycles, resp on 4th -> all stall_*=1 for 3 cycles, 0 on 4th. dstall_cnt=3.
- Branch during D-miss: br_taken=1 in cycle 2 of a 3-cycle dwait -> no flush while stalled. The flush_if_id/bubble_id_ex/flush_ex_mem triple fires for 1 cycle right after dmem_resp.
- Load-use: ex_valid=1, ex_is_load=1, ex_dest=3, id_sr2=3, id_uses_sr2=1 -> stall_if_id=1, bubble_id_ex=1 for 1 cycle, stall_id_ex=0, lu_cnt=1. With id_uses_sr2=0 -> no bubble.
- I-miss plus load-use together for 2 cycles -> bubble_id_ex=1 both cycles, istall_cnt=2, lu_cnt=0.
- Saturation: CNT_W=4, hold dwait 20 cycles -> dstall_cnt=15 and stays 15.
